// File: rtl/qa_drv_arb_pkg.sv
// Shared types and helpers for the QA driver arbiters.
package qa_drv_arb_pkg;

    localparam int MAX_CLIENTS = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } t_ARB_STATE;

    // Next round-robin position after idx, wrapping at n.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/qa_drv_tx_arb_if.sv
// Client lanes plus the single host-bound beat channel of the QA driver TX arbiter.
interface qa_drv_tx_arb_if #(
    parameter int N_CLIENTS = 4,
    parameter int UMF_WIDTH = 128
);
    logic [N_CLIENTS-1:0]           client_valid;
    logic [N_CLIENTS*UMF_WIDTH-1:0] client_data;
    logic [N_CLIENTS-1:0]           client_last;
    logic [N_CLIENTS-1:0]           client_deq;
    logic [UMF_WIDTH-1:0]           tx_data;
    logic                           tx_rdy;
    logic                           tx_enable;

    // Clients and host side.
    modport master (
        output client_valid, client_data, client_last, tx_rdy,
        input  client_deq, tx_data, tx_enable
    );

    // Arbiter side.
    modport slave (
        input  client_valid, client_data, client_last, tx_rdy,
        output client_deq, tx_data, tx_enable
    );
endinterface

// File: rtl/qa_drv_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above i_ptr, wrapping.
module qa_drv_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [N-1:0] w_rot;

    // Bit k of the rotated vector is request (i_ptr + k) mod N.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                o_idx   = IW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/qa_drv_tx_arb.sv
// Round-robin arbiter sharing the host-bound UMF channel; grants are held for a whole message.
module qa_drv_tx_arb
    import qa_drv_arb_pkg::*;
#(
    parameter  int UMF_WIDTH = 128,
    parameter  int N_CLIENTS = 4,
    parameter  int CNT_WIDTH = 32,
    localparam int IW        = $clog2(N_CLIENTS)
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [N_CLIENTS-1:0] en_mask,
    input  logic                 stat_clear,
    qa_drv_tx_arb_if.slave       bus,
    output logic [IW-1:0]        grant_idx,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] stat_beats,
    output logic [CNT_WIDTH-1:0] stat_msgs,
    output logic [CNT_WIDTH-1:0] stat_stalls
);

    if (N_CLIENTS < 2 || N_CLIENTS > MAX_CLIENTS) begin : g_bad_cfg
        $error("qa_drv_tx_arb: N_CLIENTS out of range");
    end

    t_ARB_STATE           r_state, w_state_n;
    logic [IW-1:0]        r_owner, w_owner_n;
    logic [IW-1:0]        r_rr_ptr, w_rr_ptr_n;
    logic [CNT_WIDTH-1:0] r_beats, r_msgs, r_stalls;

    logic [N_CLIENTS-1:0] w_elig;
    logic                 w_found;
    logic [IW-1:0]        w_cand;
    logic                 w_go;
    logic                 w_xfer;
    logic                 w_stall;
    logic [IW-1:0]        w_grant;
    logic                 w_last_sel;
    logic [UMF_WIDTH-1:0] w_tx_data;
    logic [N_CLIENTS-1:0] w_deq;

    assign w_elig = bus.client_valid & en_mask;

    qa_drv_rr_pick #(.N(N_CLIENTS)) u_pick (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_cand)
    );

    // Holding reset low blocks every transfer, so deq/enable are quiet during reset.
    assign w_go = bus.tx_rdy & resetb;

    always_comb begin
        w_state_n  = r_state;
        w_owner_n  = r_owner;
        w_rr_ptr_n = r_rr_ptr;
        w_xfer     = 1'b0;
        w_stall    = 1'b0;
        w_grant    = r_owner;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    if (w_go) begin
                        w_xfer  = 1'b1;
                        w_grant = w_cand;
                        if (bus.client_last[w_cand]) begin
                            w_rr_ptr_n = IW'(rr_wrap_inc(int'(w_cand), N_CLIENTS));
                        end else begin
                            w_state_n = ARB_LOCKED;
                            w_owner_n = w_cand;
                        end
                    end else if (!bus.tx_rdy) begin
                        w_stall = 1'b1;
                    end
                end
            end
            ARB_LOCKED: begin
                // The owner is served regardless of en_mask so a message is never split.
                if (bus.client_valid[r_owner]) begin
                    if (w_go) begin
                        w_xfer = 1'b1;
                        if (bus.client_last[r_owner]) begin
                            w_state_n  = ARB_IDLE;
                            w_rr_ptr_n = IW'(rr_wrap_inc(int'(r_owner), N_CLIENTS));
                        end
                    end else if (!bus.tx_rdy) begin
                        w_stall = 1'b1;
                    end
                end
            end
            default: w_state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_n;
            r_owner  <= w_owner_n;
            r_rr_ptr <= w_rr_ptr_n;
        end
    end

    assign w_last_sel = bus.client_last[w_grant];

    always_ff @(posedge clk) begin
        if (!resetb || stat_clear) begin
            r_beats  <= '0;
            r_msgs   <= '0;
            r_stalls <= '0;
        end else begin
            if (w_xfer) begin
                r_beats <= r_beats + CNT_WIDTH'(1);
            end
            if (w_xfer && w_last_sel) begin
                r_msgs <= r_msgs + CNT_WIDTH'(1);
            end
            if (w_stall) begin
                r_stalls <= r_stalls + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_tx_data = '0;
        w_deq     = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_grant == IW'(i)) begin
                w_tx_data = bus.client_data[i*UMF_WIDTH +: UMF_WIDTH];
                w_deq[i]  = w_xfer;
            end
        end
    end

    assign bus.tx_data    = w_tx_data;
    assign bus.tx_enable  = w_xfer;
    assign bus.client_deq = w_deq;

    assign grant_idx   = w_grant;
    assign locked      = (r_state == ARB_LOCKED);
    assign stat_beats  = r_beats;
    assign stat_msgs   = r_msgs;
    assign stat_stalls = r_stalls;

endmodule

// File: tb/tb_qa_drv_tx_arb.sv
// Table-driven bench for qa_drv_tx_arb with a data scoreboard on transferred beats.
module tb_qa_drv_tx_arb;

    localparam int N  = 4;
    localparam int UW = 128;
    localparam int CW = 8;

    logic          clk        = 1'b0;
    logic          resetb     = 1'b0;
    logic          stat_clear = 1'b0;
    logic [N-1:0]  en_mask    = '0;
    logic [1:0]    grant_idx;
    logic          locked;
    logic [CW-1:0] stat_beats;
    logic [CW-1:0] stat_msgs;
    logic [CW-1:0] stat_stalls;

    qa_drv_tx_arb_if #(.N_CLIENTS(N), .UMF_WIDTH(UW)) bus ();

    qa_drv_tx_arb #(.UMF_WIDTH(UW), .N_CLIENTS(N), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .en_mask     (en_mask),
        .stat_clear  (stat_clear),
        .bus         (bus),
        .grant_idx   (grant_idx),
        .locked      (locked),
        .stat_beats  (stat_beats),
        .stat_msgs   (stat_msgs),
        .stat_stalls (stat_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstb;
        logic [3:0] valid;
        logic [3:0] last;
        logic [3:0] en;
        logic       rdy;
        logic       clr;
        logic       exp_en;
        logic [3:0] exp_deq;
        logic [1:0] exp_g;
        logic       exp_lk;
        logic       cg;
        logic       cl;
    } vec_t;

    vec_t          tab[$];
    logic [UW-1:0] sb[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc   = 0;

    function automatic vec_t mk(input logic rstb, input logic [3:0] valid, input logic [3:0] last,
                                input logic [3:0] en, input logic rdy, input logic clr,
                                input logic exp_en, input logic [3:0] exp_deq, input logic [1:0] exp_g,
                                input logic exp_lk, input logic cg, input logic cl);
        vec_t v;
        v.rstb = rstb;   v.valid = valid;     v.last  = last;  v.en     = en;
        v.rdy  = rdy;    v.clr   = clr;       v.exp_en = exp_en;
        v.exp_deq = exp_deq; v.exp_g = exp_g; v.exp_lk = exp_lk;
        v.cg = cg;       v.cl = cl;
        return v;
    endfunction

    function automatic logic [UW-1:0] mkdata(input int lane, input int c);
        return {8'(lane), 88'h5A, 32'(c)};
    endfunction

    task automatic chk(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [UW-1:0] e;
        @(negedge clk);
        resetb           = v.rstb;
        bus.client_valid = v.valid;
        bus.client_last  = v.last;
        en_mask          = v.en;
        bus.tx_rdy       = v.rdy;
        stat_clear       = v.clr;
        for (int i = 0; i < N; i++) bus.client_data[i*UW +: UW] = mkdata(i, cyc);
        #1;
        chk({tag, ".tx_enable"}, UW'(bus.tx_enable), UW'(v.exp_en));
        chk({tag, ".deq"}, UW'(bus.client_deq), UW'(v.exp_deq));
        if (v.cg) chk({tag, ".grant"}, UW'(grant_idx), UW'(v.exp_g));
        if (v.cl) chk({tag, ".locked"}, UW'(locked), UW'(v.exp_lk));
        if (v.exp_en) sb.push_back(mkdata(int'(v.exp_g), cyc));
        if (bus.tx_enable) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_unexpected"}, UW'(bus.tx_enable), UW'(0));
            end else begin
                e = sb.pop_front();
                chk({tag, ".tx_data"}, bus.tx_data, e);
            end
        end
        cyc++;
    endtask

    task automatic run_tab(input string tag);
        for (int i = 0; i < tab.size(); i++) apply(tab[i], $sformatf("%s[%0d]", tag, i));
        tab.delete();
    endtask

    task automatic do_reset(input string tag);
        tab.push_back(mk(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0));
        tab.push_back(mk(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1));
        run_tab(tag);
        chk({tag, ".beats"}, UW'(stat_beats), UW'(0));
        chk({tag, ".msgs"}, UW'(stat_msgs), UW'(0));
        chk({tag, ".stalls"}, UW'(stat_stalls), UW'(0));
    endtask

    initial begin
        bus.client_valid = '0;
        bus.client_last  = '0;
        bus.client_data  = '0;
        bus.tx_rdy       = 1'b0;

        // Continuous single-beat messages from all clients: strict rotation.
        do_reset("rst_rr");
        for (int k = 0; k < 8; k++)
            tab.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'(1 << (k % 4)), 2'(k % 4), 1'b0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1));
        run_tab("rr");
        chk("rr.msgs", UW'(stat_msgs), UW'(8));
        chk("rr.beats", UW'(stat_beats), UW'(8));
        chk("rr.stalls", UW'(stat_stalls), UW'(0));

        // Three-beat message from client 1 while client 2 waits.
        do_reset("rst_lock");
        tab.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0110, 4'b0010, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0100, 4'b0100, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1));
        run_tab("lock");
        chk("lock.msgs", UW'(stat_msgs), UW'(2));
        chk("lock.beats", UW'(stat_beats), UW'(4));

        // Client 0 disabled mid-message: message finishes, then no new grant.
        do_reset("rst_mask");
        tab.push_back(mk(1'b1, 4'b0001, 4'b0000, 4'hF,    1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0011, 4'b0000, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0011, 4'b0001, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0011, 4'b0011, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0001, 4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1));
        run_tab("mask");
        chk("mask.stalls", UW'(stat_stalls), UW'(0));

        // Host back-pressure: five stalled cycles, pointer must not move.
        do_reset("rst_stall");
        tab.push_back(mk(1'b1, 4'b0010, 4'b0010, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1));
        for (int k = 0; k < 5; k++)
            tab.push_back(mk(1'b1, 4'b1000, 4'b1000, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b1001, 4'b1001, 4'hF, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1));
        run_tab("stall");
        chk("stall.stalls", UW'(stat_stalls), UW'(5));
        chk("stall.beats", UW'(stat_beats), UW'(1));

        // Reset pulse while client 2 holds the lock.
        do_reset("rst_mid");
        tab.push_back(mk(1'b1, 4'b0100, 4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0100, 4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0100, 4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1));
        run_tab("mid_a");
        chk("mid.stalls_pre", UW'(stat_stalls), UW'(1));
        chk("mid.beats_pre", UW'(stat_beats), UW'(1));
        tab.push_back(mk(1'b0, 4'b0101, 4'b0101, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1));
        tab.push_back(mk(1'b0, 4'b0101, 4'b0101, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 4'b0101, 4'b0101, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1));
        run_tab("mid_b");
        chk("mid.beats_post", UW'(stat_beats), UW'(0));
        chk("mid.stalls_post", UW'(stat_stalls), UW'(0));

        // Counter saturation corner: clear wins over increment, then plain wrap.
        do_reset("rst_wrap");
        for (int k = 0; k < 255; k++)
            tab.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'(1 << (k % 4)), 2'(k % 4), 1'b0, 1'b1, 1'b1));
        run_tab("fill1");
        tab.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1));
        run_tab("clr");
        chk("clr.beats_full", UW'(stat_beats), UW'(8'hFF));
        tab.push_back(mk(1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1));
        run_tab("clr_after");
        chk("clr.beats", UW'(stat_beats), UW'(0));
        chk("clr.msgs", UW'(stat_msgs), UW'(0));
        for (int k = 0; k < 255; k++)
            tab.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'(1 << (k % 4)), 2'(k % 4), 1'b0, 1'b1, 1'b1));
        run_tab("fill2");
        tab.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1));
        run_tab("wrap");
        chk("wrap.beats_full", UW'(stat_beats), UW'(8'hFF));
        tab.push_back(mk(1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1));
        run_tab("wrap_after");
        chk("wrap.beats", UW'(stat_beats), UW'(0));
        chk("wrap.msgs", UW'(stat_msgs), UW'(0));

        chk("sb.drain", UW'(sb.size()), UW'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
